exec_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline; sits between decode and the memory stage.
- Takes decoded operands and controls from decode, then computes the ALU result.
- Registers the result plus pass-through controls into the ac_* pipeline registers that feed the memory stage.
- Contains an iterative 32-cycle multiply/divide unit. While that unit is busy, the stage stalls decode and fetch.

---
 rtl/exec_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_exec_stage.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage of the RV32 pipeline: single-cycle ALU plus an iterative
// multiply/divide unit, registering results into the ac_* pipeline registers.
module exec_stage #(
    parameter int unsigned XLEN      = 32,
    parameter bit          ENABLE_MD = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] db_pc,
    input  logic [4:0]      db_write_sel,
    input  logic [XLEN-1:0] db_data1,
    input  logic [XLEN-1:0] db_data2,
    input  logic [XLEN-1:0] db_imm,
    input  logic            db_use_imm,
    input  logic [3:0]      db_alu_op,
    input  logic            db_is_load,
    input  logic            db_is_store,
    input  logic            db_is_wb,
    input  logic            flush,
    input  logic            dcache_stall,
    output logic [XLEN-1:0] ac_pc,
    output logic [4:0]      ac_write_sel,
    output logic [XLEN-1:0] ALU_result,
    output logic [XLEN-1:0] ac_data2,
    output logic            ac_is_load,
    output logic            ac_is_store,
    output logic            ac_is_wb,
    output logic            ex_stall
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MD_MUL,
        MD_DIVU,
        MD_REMU
    } md_kind_t;

    logic [XLEN-1:0] opnd_a;
    logic [XLEN-1:0] opnd_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_out;
    logic            is_md_op;
    logic            md_start;

    state_t          state;
    state_t          state_nxt;
    logic [4:0]      step_cnt;
    logic [4:0]      step_cnt_nxt;

    md_kind_t        md_kind;
    logic [XLEN-1:0] md_acc;
    logic [XLEN-1:0] md_x;
    logic [XLEN-1:0] md_y;
    logic [XLEN-1:0] md_acc_step;
    logic [XLEN-1:0] md_x_step;
    logic [XLEN-1:0] md_y_step;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff;
    logic [XLEN-1:0] md_result;

    assign opnd_a = db_data1;
    assign opnd_b = db_use_imm ? db_imm : db_data2;
    assign shamt  = opnd_b[4:0];

    assign is_md_op = ENABLE_MD &&
                      (db_alu_op inside {OP_MUL, OP_DIVU, OP_REMU});
    assign md_start = (state == IDLE) && is_md_op && !flush && !dcache_stall;

    always_comb begin
        alu_out = '0;
        case (db_alu_op)
            OP_ADD:  alu_out = opnd_a + opnd_b;
            OP_SUB:  alu_out = opnd_a - opnd_b;
            OP_AND:  alu_out = opnd_a & opnd_b;
            OP_OR:   alu_out = opnd_a | opnd_b;
            OP_XOR:  alu_out = opnd_a ^ opnd_b;
            OP_SLL:  alu_out = opnd_a << shamt;
            OP_SRL:  alu_out = opnd_a >> shamt;
            OP_SRA:  alu_out = $signed(opnd_a) >>> shamt;
            OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(opnd_a) < $signed(opnd_b)};
            OP_SLTU: alu_out = {{(XLEN-1){1'b0}}, opnd_a < opnd_b};
            default: alu_out = '0;
        endcase
    end

    // Shared datapath: md_acc is product accumulator or partial remainder,
    // md_x is shifted multiplicand or quotient, md_y is multiplier or divisor.
    always_comb begin
        md_acc_step = md_acc;
        md_x_step   = md_x;
        md_y_step   = md_y;
        rem_shift   = {md_acc, md_x[XLEN-1]};
        rem_diff    = rem_shift[XLEN-1:0] - md_y;
        if (md_kind == MD_MUL) begin
            if (md_y[0]) begin
                md_acc_step = md_acc + md_x;
            end
            md_x_step = md_x << 1;
            md_y_step = md_y >> 1;
        end else begin
            // Divide by zero falls out naturally: every step subtracts zero,
            // so the quotient fills with ones and the remainder becomes A.
            if (rem_shift >= {1'b0, md_y}) begin
                md_acc_step = rem_diff;
                md_x_step   = {md_x[XLEN-2:0], 1'b1};
            end else begin
                md_acc_step = rem_shift[XLEN-1:0];
                md_x_step   = {md_x[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        case (md_kind)
            MD_DIVU: md_result = md_x;
            default: md_result = md_acc;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_kind <= MD_MUL;
            md_acc  <= '0;
            md_x    <= '0;
            md_y    <= '0;
        end else if (md_start) begin
            case (db_alu_op)
                OP_DIVU: md_kind <= MD_DIVU;
                OP_REMU: md_kind <= MD_REMU;
                default: md_kind <= MD_MUL;
            endcase
            md_acc <= '0;
            md_x   <= opnd_a;
            md_y   <= opnd_b;
        end else if (state == BUSY && !flush) begin
            md_acc <= md_acc_step;
            md_x   <= md_x_step;
            md_y   <= md_y_step;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            step_cnt <= '0;
        end else begin
            state    <= state_nxt;
            step_cnt <= step_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = step_cnt;
        case (state)
            IDLE: begin
                if (md_start) begin
                    state_nxt    = BUSY;
                    step_cnt_nxt = '0;
                end
            end
            BUSY: begin
                step_cnt_nxt = step_cnt + 5'd1;
                if (step_cnt == 5'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!dcache_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt    = IDLE;
            step_cnt_nxt = '0;
        end
    end

    assign ex_stall = reset && !flush &&
                      (((state == IDLE) && is_md_op) ||
                       (state == BUSY) ||
                       ((state == DONE) && dcache_stall));

    // dcache_stall outranks flush here: ac_* still holds an older live instruction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ac_pc        <= '0;
            ac_write_sel <= '0;
            ALU_result   <= '0;
            ac_data2     <= '0;
            ac_is_load   <= 1'b0;
            ac_is_store  <= 1'b0;
            ac_is_wb     <= 1'b0;
        end else if (!dcache_stall) begin
            if (flush || state == BUSY || (state == IDLE && is_md_op)) begin
                ac_pc        <= '0;
                ac_write_sel <= '0;
                ALU_result   <= '0;
                ac_data2     <= '0;
                ac_is_load   <= 1'b0;
                ac_is_store  <= 1'b0;
                ac_is_wb     <= 1'b0;
            end else begin
                ac_pc        <= db_pc;
                ac_write_sel <= db_write_sel;
                ALU_result   <= (state == DONE) ? md_result : alu_out;
                ac_data2     <= db_data2;
                ac_is_load   <= db_is_load;
                ac_is_store  <= db_is_store;
                ac_is_wb     <= db_is_wb;
            end
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Randomized self-checking bench for exec_stage against an arithmetic
// reference model of results, bubbles, holds and multi-cycle latency.
module tb_exec_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] db_pc = '0;
    logic [4:0]  db_write_sel = '0;
    logic [31:0] db_data1 = '0;
    logic [31:0] db_data2 = '0;
    logic [31:0] db_imm = '0;
    logic        db_use_imm = 1'b0;
    logic [3:0]  db_alu_op = '0;
    logic        db_is_load = 1'b0;
    logic        db_is_store = 1'b0;
    logic        db_is_wb = 1'b0;
    logic        flush = 1'b0;
    logic        dcache_stall = 1'b0;
    logic [31:0] ac_pc;
    logic [4:0]  ac_write_sel;
    logic [31:0] ALU_result;
    logic [31:0] ac_data2;
    logic        ac_is_load;
    logic        ac_is_store;
    logic        ac_is_wb;
    logic        ex_stall;

    always #5 clock = ~clock;

    exec_stage #(.XLEN(32), .ENABLE_MD(1'b1)) dut (
        .clock(clock), .reset(reset),
        .db_pc(db_pc), .db_write_sel(db_write_sel),
        .db_data1(db_data1), .db_data2(db_data2), .db_imm(db_imm),
        .db_use_imm(db_use_imm), .db_alu_op(db_alu_op),
        .db_is_load(db_is_load), .db_is_store(db_is_store), .db_is_wb(db_is_wb),
        .flush(flush), .dcache_stall(dcache_stall),
        .ac_pc(ac_pc), .ac_write_sel(ac_write_sel), .ALU_result(ALU_result),
        .ac_data2(ac_data2), .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
        .ac_is_wb(ac_is_wb), .ex_stall(ex_stall)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Expected contents of the ac_* registers.
    logic [31:0] e_pc = '0;
    logic [4:0]  e_sel = '0;
    logic [31:0] e_res = '0;
    logic [31:0] e_d2 = '0;
    logic        e_ld = 1'b0;
    logic        e_st = 1'b0;
    logic        e_wb = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] prod;
        logic [4:0]  sh;
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd12: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opnd_b();
        return db_use_imm ? db_imm : db_data2;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge(input bit bubble, input logic [31:0] res);
        if (dcache_stall) return;
        if (flush || bubble) begin
            e_pc = '0; e_sel = '0; e_res = '0; e_d2 = '0;
            e_ld = 1'b0; e_st = 1'b0; e_wb = 1'b0;
        end else begin
            e_pc = db_pc; e_sel = db_write_sel; e_res = res; e_d2 = db_data2;
            e_ld = db_is_load; e_st = db_is_store; e_wb = db_is_wb;
        end
    endtask

    task automatic model_zero();
        e_pc = '0; e_sel = '0; e_res = '0; e_d2 = '0;
        e_ld = 1'b0; e_st = 1'b0; e_wb = 1'b0;
    endtask

    task automatic check_ac(input string tag);
        check({tag, ".pc"},    ac_pc,        e_pc);
        check({tag, ".sel"},   32'(ac_write_sel), 32'(e_sel));
        check({tag, ".res"},   ALU_result,   e_res);
        check({tag, ".d2"},    ac_data2,     e_d2);
        check({tag, ".flags"}, {29'd0, ac_is_load, ac_is_store, ac_is_wb},
                               {29'd0, e_ld, e_st, e_wb});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d2,
                         input logic [31:0] imm, input logic use_imm, input logic [2:0] flags,
                         input logic [4:0] sel, input logic [31:0] pc);
        db_alu_op = op; db_data1 = a; db_data2 = d2; db_imm = imm; db_use_imm = use_imm;
        {db_is_load, db_is_store, db_is_wb} = flags;
        db_write_sel = sel; db_pc = pc;
        #1;
    endtask

    task automatic step_single(input string tag);
        check({tag, ".stall"}, {31'd0, ex_stall}, 32'd0);
        model_edge(1'b0, ref_result(db_alu_op, db_data1, opnd_b()));
        tick();
        check_ac(tag);
    endtask

    // Present an MD op and expect 33 stall cycles of bubbles, capture on edge 34.
    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int unsigned stalls;
        int unsigned bad_bubbles;
        logic [31:0] expv;
        stalls = 0;
        bad_bubbles = 0;
        expv = ref_result(op, a, b);
        drive(op, a, b, 32'h0, 1'b0, 3'b001, 5'd9, 32'h0000_4000 + {28'd0, op});
        for (int i = 0; i < 33; i++) begin
            if (ex_stall) stalls++;
            model_edge(1'b1, '0);
            tick();
            if (ac_is_wb || ac_is_load || ac_is_store || ac_write_sel != 0) bad_bubbles++;
        end
        check({tag, ".stall_cycles"}, stalls, 33);
        check({tag, ".bubbles"}, bad_bubbles, 0);
        check({tag, ".done_stall"}, {31'd0, ex_stall}, 32'd0);
        model_edge(1'b0, expv);
        tick();
        check_ac(tag);
    endtask

    task automatic check_all_zero(input string tag);
        model_zero();
        check_ac(tag);
        check({tag, ".stall"}, {31'd0, ex_stall}, 32'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned r;

        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        tick();
        check_all_zero("after_reset");

        drive(4'd0, 32'h7FFF_FFFF, 32'h1234_5678, 32'd1, 1'b1, 3'b001, 5'd3, 32'h0000_0100);
        step_single("add");
        check("add.exact", ALU_result, 32'h8000_0000);
        drive(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'b001, 5'd4, 32'h104);
        step_single("sltu");
        check("sltu.exact", ALU_result, 32'd1);
        drive(4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'b001, 5'd4, 32'h108);
        step_single("slt");
        check("slt.exact", ALU_result, 32'd0);
        drive(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 3'b001, 5'd5, 32'h10C);
        step_single("sra");
        check("sra.exact", ALU_result, 32'hF800_0000);

        run_md("mul1", 4'd10, 32'h0001_0003, 32'h0000_0010);
        check("mul1.exact", ALU_result, 32'h0010_0030);
        run_md("mul2", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul2.exact", ALU_result, 32'h0000_0001);
        run_md("divu", 4'd11, 32'd100, 32'd7);
        check("divu.exact", ALU_result, 32'd14);
        run_md("remu", 4'd12, 32'd100, 32'd7);
        check("remu.exact", ALU_result, 32'd2);
        run_md("divu0", 4'd11, 32'd5, 32'd0);
        check("divu0.exact", ALU_result, 32'hFFFF_FFFF);
        run_md("remu0", 4'd12, 32'd5, 32'd0);
        check("remu0.exact", ALU_result, 32'd5);

        // dcache_stall spanning the end of BUSY and two DONE cycles
        drive(4'd11, 32'd1000, 32'd3, 32'd0, 1'b0, 3'b001, 5'd7, 32'h200);
        for (int i = 0; i < 30; i++) begin
            model_edge(1'b1, '0);
            tick();
        end
        dcache_stall = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("dstall.ex", {31'd0, ex_stall}, 32'd1);
            model_edge(1'b0, '0);
            tick();
            check_ac("dstall.hold");
        end
        dcache_stall = 1'b0;
        #1;
        check("dstall.release", {31'd0, ex_stall}, 32'd0);
        model_edge(1'b0, 32'd333);
        tick();
        check_ac("dstall.capture");

        // flush + dcache_stall holds a live result; flush alone bubbles
        drive(4'd0, 32'd5, 32'd6, 32'd0, 1'b0, 3'b011, 5'd12, 32'h300);
        step_single("pre_hold");
        flush = 1'b1; dcache_stall = 1'b1;
        drive(4'd0, 32'd100, 32'd1, 32'd0, 1'b0, 3'b001, 5'd13, 32'h304);
        model_edge(1'b0, 32'd101);
        tick();
        check_ac("flush_dstall_hold");
        dcache_stall = 1'b0;
        #1;
        model_edge(1'b0, 32'd101);
        tick();
        check_ac("flush_bubble");
        flush = 1'b0;

        for (int pass = 0; pass < 2; pass++) begin
            drive(4'd10, 32'd7, 32'd9, 32'd0, 1'b0, 3'b001, 5'd14, 32'h400);
            for (int i = 0; i < 11; i++) begin
                model_edge(1'b1, '0);
                tick();
            end
            flush = 1'b1;
            dcache_stall = (pass == 1);
            #1;
            check("flush.ex_stall", {31'd0, ex_stall}, 32'd0);
            model_edge(1'b1, '0);
            tick();
            check_ac("flush.mid_busy");
            flush = 1'b0;
            dcache_stall = 1'b0;
            drive(4'd0, 32'd40, 32'd2, 32'd0, 1'b0, 3'b001, 5'd15, 32'h408);
            step_single("flush.next_add");
            check("flush.next_add.exact", ALU_result, 32'd42);
        end

        // asynchronous reset with a live result, then mid-multiply
        drive(4'd3, 32'hA0A0_0000, 32'h0000_0505, 32'd0, 1'b0, 3'b101, 5'd17, 32'h500);
        step_single("pre_reset");
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        #1 reset = 1'b1;
        drive(4'd10, 32'h1234, 32'h55, 32'd0, 1'b0, 3'b001, 5'd18, 32'h504);
        for (int i = 0; i < 10; i++) begin
            model_edge(1'b1, '0);
            tick();
        end
        #2 reset = 1'b0;
        #1 check_all_zero("reset_mid_mul");
        #1 reset = 1'b1;
        run_md("mul_after_reset", 4'd10, 32'd3, 32'd5);
        check("mul_after_reset.exact", ALU_result, 32'd15);

        // randomized single-cycle ops with occasional flush / dcache_stall
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 12);
            op = (r >= 10) ? 4'(r + 3) : 4'(r);
            flush = ($urandom_range(0, 7) == 0);
            dcache_stall = ($urandom_range(0, 5) == 0);
            drive(op, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom);
            step_single("rand_alu");
            flush = 1'b0;
            dcache_stall = 1'b0;
        end

        // randomized multiply/divide
        for (int i = 0; i < 8; i++) begin
            op = 4'(10 + $urandom_range(0, 2));
            a = $urandom;
            r = $urandom_range(0, 3);
            b = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 255)) : $urandom;
            run_md("rand_md", op, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
